// File: rtl/fetch_decode_queue.sv
// Instruction queue between fetch and decode: in-order {pc, instruction} buffer, emptied on branch redirect.
// Optional macro FDQ_BYPASS_EN lets a fetched pair reach decode in the same cycle when the queue is empty.

`ifndef WORD
`define WORD 64
`endif
`ifndef INSTR_LEN
`define INSTR_LEN 32
`endif

module fetch_decode_queue #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  fetch_valid,
    input  logic [`WORD-1:0]      fetch_pc,
    input  logic [`INSTR_LEN-1:0] fetch_instruction,
    output logic                  fetch_ready,
    output logic                  dec_valid,
    output logic [`WORD-1:0]      dec_pc,
    output logic [`INSTR_LEN-1:0] dec_instruction,
    input  logic                  dec_ready,
    output logic [PTR_W:0]        count
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [`WORD-1:0]      pc_mem    [DEPTH];
    logic [`INSTR_LEN-1:0] instr_mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic                  empty;
    logic                  full;
    logic                  bypass;
    logic                  push;
    logic                  pop;

    assign empty = (count == '0);
    assign full  = (count == FULL_CNT);

`ifdef FDQ_BYPASS_EN
    assign bypass = empty && fetch_valid && !flush;
`else
    assign bypass = 1'b0;
`endif

    assign fetch_ready = !full && !flush;
    assign dec_valid   = !empty || bypass;

    // A bypassed pair that decode takes immediately is never stored.
    assign push = fetch_valid && fetch_ready && !(bypass && dec_ready);
    assign pop  = !empty && dec_ready;

    always_comb begin
        dec_pc          = '0;
        dec_instruction = '0;
        if (!empty) begin
            dec_pc          = pc_mem[rd_ptr];
            dec_instruction = instr_mem[rd_ptr];
        end else if (bypass) begin
            dec_pc          = fetch_pc;
            dec_instruction = fetch_instruction;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]    <= fetch_pc;
            instr_mem[wr_ptr] <= fetch_instruction;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule
